// File: rtl/memory_stage_pkg.sv
// Shared constants and types for the Beta MEM stage: IR source encodings,
// canned instructions, memory opcodes and the data-memory FSM state.
package memory_stage_pkg;

  localparam logic [1:0] IR_SRC_EXCEPT = 2'd0;
  localparam logic [1:0] IR_SRC_NOP    = 2'd1;
  localparam logic [1:0] IR_SRC_DATA   = 2'd2;

  // ADDC(R31, 0, R31) and BNE(R31, XP handler, XP)
  localparam logic [31:0] INST_NOP        = 32'hC3FF_0000;
  localparam logic [31:0] INST_BNE_EXCEPT = 32'h7BDF_FFFF;

  localparam logic [5:0] OPCODE_LD  = 6'h18;
  localparam logic [5:0] OPCODE_ST  = 6'h19;
  localparam logic [5:0] OPCODE_LDR = 6'h1F;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OPCODE_LD) || (op == OPCODE_ST) || (op == OPCODE_LDR);
  endfunction

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OPCODE_LD) || (op == OPCODE_LDR);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface memory_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_stage_dmem_if.sv
// Data-memory access sequencer: IDLE/WAIT FSM, wait counter and timeout abort.
module dmem_if
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op_i,
  input  logic ack_i,
  output logic req_o,
  output logic stall_o,
  output logic timeout_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_fired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An ack in the last allowed cycle beats the timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    timeout_fired = (state_q == MEM_WAIT) && (cnt_q == CNT_LAST) && !ack_i;
    req_o         = mem_op_i && !timeout_fired;
    stall_o       = req_o && !ack_i;
    timeout_o     = timeout_fired;
    case (state_q)
      MEM_IDLE: begin
        if (mem_op_i && !ack_i) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (ack_i || timeout_fired) state_d = MEM_IDLE;
        else                        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Beta MEM stage: pipeline registers, data-memory access and writeback muxes.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_stage_if.master       dmem,
  input  logic [1:0]           ir_src_mem_i,
  input  logic [31:0]          pc_mem_next_i,
  input  logic [31:0]          ir_mem_next_i,
  input  logic [31:0]          y_mem_next_i,
  input  logic [31:0]          st_mem_next_i,
  output logic                 stall_mem_o,
  output logic                 mem_timeout_o,
  output logic [31:0]          pc_wb_next_o,
  output logic [31:0]          ir_wb_next_o,
  output logic [31:0]          y_wb_next_o
);

  logic [31:0] pc_mem_q, ir_mem_q, y_mem_q, st_mem_q;
  logic [31:0] pc_mem_d, ir_mem_d, y_mem_d, st_mem_d;
  logic        mem_op, ack_valid, req, stall, timeout;

  assign pc_mem_d = stall ? pc_mem_q : pc_mem_next_i;
  assign ir_mem_d = stall ? ir_mem_q : ir_mem_next_i;
  assign y_mem_d  = stall ? y_mem_q  : y_mem_next_i;
  assign st_mem_d = stall ? st_mem_q : st_mem_next_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_mem_q <= '0;
      ir_mem_q <= INST_NOP;
      y_mem_q  <= '0;
      st_mem_q <= '0;
    end else begin
      pc_mem_q <= pc_mem_d;
      ir_mem_q <= ir_mem_d;
      y_mem_q  <= y_mem_d;
      st_mem_q <= st_mem_d;
    end
  end

  assign mem_op = is_mem_op(ir_mem_q[31:26]);

  dmem_if #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dmem_if (
    .clk      (clk),
    .rst      (rst),
    .mem_op_i (mem_op),
    .ack_i    (dmem.dmem_ack),
    .req_o    (req),
    .stall_o  (stall),
    .timeout_o(timeout)
  );

  // Bus fields come straight from the registers so they hold during a stall.
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = (ir_mem_q[31:26] == OPCODE_ST);
  assign dmem.dmem_addr  = {y_mem_q[31:2], 2'b00};
  assign dmem.dmem_wdata = st_mem_q;

  assign ack_valid     = dmem.dmem_ack && req;
  assign stall_mem_o   = stall;
  assign mem_timeout_o = timeout;
  assign pc_wb_next_o  = pc_mem_q;
  assign y_wb_next_o   = (is_load_op(ir_mem_q[31:26]) && ack_valid) ? dmem.dmem_rdata : y_mem_q;

  always_comb begin
    ir_wb_next_o = 'x;
    if (timeout) begin
      ir_wb_next_o = INST_BNE_EXCEPT;
    end else if (stall) begin
      ir_wb_next_o = INST_NOP;
    end else begin
      case (ir_src_mem_i)
        IR_SRC_EXCEPT: ir_wb_next_o = INST_BNE_EXCEPT;
        IR_SRC_NOP:    ir_wb_next_o = INST_NOP;
        IR_SRC_DATA:   ir_wb_next_o = ir_mem_q;
        default:       ir_wb_next_o = 'x;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with TIMEOUT_CYCLES = 4.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ir_src_mem;
  logic [31:0] pc_next, ir_next, y_next, st_next;
  logic        stall_mem, mem_timeout;
  logic [31:0] pc_wb, ir_wb, y_wb;
  int          total = 0;
  int          bad = 0;
  int          nstall;

  localparam logic [31:0] I_ADD = {6'h20, 5'd1, 5'd2, 5'd3, 11'd0};
  localparam logic [31:0] I_LD  = {6'h18, 5'd4, 5'd0, 16'h0000};
  localparam logic [31:0] I_ST  = {6'h19, 5'd5, 5'd0, 16'h0000};
  localparam logic [31:0] I_LDR = {6'h1F, 5'd6, 5'd31, 16'h0000};

  memory_stage_if bus();

  memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem         (bus.master),
    .ir_src_mem_i (ir_src_mem),
    .pc_mem_next_i(pc_next),
    .ir_mem_next_i(ir_next),
    .y_mem_next_i (y_next),
    .st_mem_next_i(st_next),
    .stall_mem_o  (stall_mem),
    .mem_timeout_o(mem_timeout),
    .pc_wb_next_o (pc_wb),
    .ir_wb_next_o (ir_wb),
    .y_wb_next_o  (y_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_next(input logic [31:0] ir, input logic [31:0] pc,
                          input logic [31:0] y, input logic [31:0] st);
    ir_next = ir; pc_next = pc; y_next = y; st_next = st;
  endtask

  initial begin
    ir_src_mem = IR_SRC_DATA;
    set_next(INST_NOP, 32'h0, 32'h0, 32'h0);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_tmo", {31'd0, mem_timeout}, 32'd0);
    chk("rst_ir", ir_wb, INST_NOP);
    chk("rst_pc", pc_wb, 32'h0);
    chk("rst_y", y_wb, 32'h0);
    rst = 1'b0;

    // Non-memory instruction
    tick();
    set_next(I_ADD, 32'h100, 32'h10, 32'h0);
    tick();
    set_next(INST_NOP, 32'h104, 32'h0, 32'h0);
    #1;
    chk("add_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("add_stall", {31'd0, stall_mem}, 32'd0);
    chk("add_y", y_wb, 32'h10);
    chk("add_pc", pc_wb, 32'h100);
    chk("add_ir", ir_wb, I_ADD);
    ir_src_mem = IR_SRC_EXCEPT; #1;
    chk("src_except", ir_wb, INST_BNE_EXCEPT);
    ir_src_mem = IR_SRC_NOP; #1;
    chk("src_nop", ir_wb, INST_NOP);
    ir_src_mem = IR_SRC_DATA;

    // Zero-wait LD, then back-to-back LDR, ack held high
    set_next(I_LD, 32'h200, 32'h103, 32'h0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
    tick();
    set_next(I_LDR, 32'h204, 32'h22, 32'h0);
    #1;
    chk("ld0_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("ld0_addr", bus.dmem_addr, 32'h100);
    chk("ld0_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("ld0_stall", {31'd0, stall_mem}, 32'd0);
    chk("ld0_y", y_wb, 32'hDEAD_BEEF);
    chk("ld0_ir", ir_wb, I_LD);
    tick();
    set_next(INST_NOP, 32'h208, 32'h0, 32'h0);
    bus.dmem_rdata = 32'h0BAD_F00D; #1;
    chk("b2b_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("b2b_addr", bus.dmem_addr, 32'h20);
    chk("b2b_y", y_wb, 32'h0BAD_F00D);
    tick(); #1;
    chk("idle_ack_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("idle_ack_y", y_wb, 32'h0);
    bus.dmem_ack = 1'b0;

    // ST with three wait cycles
    set_next(I_ST, 32'h300, 32'h206, 32'h1234_5678);
    tick();
    set_next(INST_NOP, 32'h304, 32'h0, 32'h0);
    nstall = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) ir_src_mem = IR_SRC_NOP;
      #1;
      if (stall_mem) nstall++;
      chk("st_we", {31'd0, bus.dmem_we}, 32'd1);
      chk("st_addr", bus.dmem_addr, 32'h204);
      chk("st_wdata", bus.dmem_wdata, 32'h1234_5678);
      chk("st_bubble", ir_wb, INST_NOP);
      tick();
    end
    ir_src_mem = IR_SRC_DATA;
    bus.dmem_ack = 1'b1; #1;
    chk("st_nstall", nstall, 32'd3);
    chk("st_ack_stall", {31'd0, stall_mem}, 32'd0);
    chk("st_ack_ir", ir_wb, I_ST);
    chk("st_ack_pc", pc_wb, 32'h300);
    tick();
    bus.dmem_ack = 1'b0; #1;
    chk("st_after_req", {31'd0, bus.dmem_req}, 32'd0);

    // LD timeout: four stalled cycles, abort on the fifth
    set_next(I_LD, 32'h400, 32'h40, 32'h0);
    tick();
    set_next(I_ADD, 32'h404, 32'h55, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tmo_wait_stall", {31'd0, stall_mem}, 32'd1);
      chk("tmo_wait_pulse", {31'd0, mem_timeout}, 32'd0);
      tick();
    end
    #1;
    chk("tmo_pulse", {31'd0, mem_timeout}, 32'd1);
    chk("tmo_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("tmo_stall", {31'd0, stall_mem}, 32'd0);
    chk("tmo_ir", ir_wb, INST_BNE_EXCEPT);
    chk("tmo_pc", pc_wb, 32'h400);
    tick();
    set_next(INST_NOP, 32'h408, 32'h0, 32'h0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_2222; #1;
    chk("post_tmo_pulse", {31'd0, mem_timeout}, 32'd0);
    chk("post_tmo_ir", ir_wb, I_ADD);
    chk("post_tmo_y", y_wb, 32'h55);
    chk("post_tmo_req", {31'd0, bus.dmem_req}, 32'd0);
    tick();
    bus.dmem_ack = 1'b0;

    // Ack in the timeout cycle wins
    set_next(I_LD, 32'h500, 32'h80, 32'h0);
    bus.dmem_rdata = 32'hCAFE_F00D;
    tick();
    set_next(INST_NOP, 32'h504, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    bus.dmem_ack = 1'b1; #1;
    chk("race_pulse", {31'd0, mem_timeout}, 32'd0);
    chk("race_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("race_stall", {31'd0, stall_mem}, 32'd0);
    chk("race_y", y_wb, 32'hCAFE_F00D);
    chk("race_ir", ir_wb, I_LD);
    tick();
    bus.dmem_ack = 1'b0; #1;
    chk("race_after_ir", ir_wb, INST_NOP);

    // Reset in the middle of a pending LD
    set_next(I_LD, 32'h600, 32'h60, 32'h0);
    tick();
    set_next(INST_NOP, 32'h0, 32'h0, 32'h0);
    tick(); #1;
    chk("mid_stall", {31'd0, stall_mem}, 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("mid_rst_ir", ir_wb, INST_NOP);
    tick();
    rst = 1'b0;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h9999_9999; #1;
    chk("late_ack_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("late_ack_y", y_wb, 32'h0);
    chk("late_ack_ir", ir_wb, INST_NOP);
    tick(); #1;
    chk("late_ack_stall", {31'd0, stall_mem}, 32'd0);
    chk("late_ack_pc", pc_wb, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory (MEM) stage of the five-stage Beta pipeline. It registers the PC, IR, Y and ST values produced by the execute stage and performs the data-memory access for LD, ST and LDR over a req/ack bus. It then presents PC, IR and the result (ALU Y or load data) to the writeback stage. While an access is outstanding it stalls the upstream stages, and it converts a bus timeout into an exception bubble.

## Interface
- TIMEOUT_CYCLES, 255: wait cycles allowed for dmem_ack before the access is abandoned (1..255).
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- ir_src_mem  input  2  IR source for writeback (IR_SRC_EXCEPT / IR_SRC_NOP / IR_SRC_DATA), same encoding as the execute stage.
- pc_mem_next  input  32  next PC from execute.
- ir_mem_next  input  32  next IR from execute.
- y_mem_next  input  32  ALU result from execute; this is the address for LD/ST/LDR.
- st_mem_next  input  32  store data from execute.
- dmem_req  output  1  access request.
- dmem_we  output  1  1 = write (ST), 0 = read.
- dmem_addr  output  32  word address, y_mem with bits [1:0] forced to 0.
- dmem_wdata  output  32  store data.
- dmem_ack  input  1  access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  input  32  read data.
- stall_mem  output  1  freezes the PC, IF, RF and EXE pipeline registers.
- mem_timeout  output  1  one-cycle pulse when an access is abandoned.
- pc_wb_next  output  32  PC to writeback.
- ir_wb_next  output  32  IR to writeback.
- y_wb_next  output  32  result to writeback.

## Operation
- Pipeline registers: pc_mem, ir_mem, y_mem, st_mem.
  - They load from the *_next inputs on every clk edge when stall_mem = 0.
  - They hold when stall_mem = 1.
- A memory op is an ir_mem opcode of OPCODE_LD (6'h18), OPCODE_ST (6'h19) or OPCODE_LDR (6'h1F).
- FSM states:
  - IDLE: the access is issued here.
  - WAIT: the access is outstanding and the ack has not been seen.
- FSM transitions:
  - IDLE → WAIT when a memory op is present and dmem_ack = 0.
  - IDLE stays IDLE when dmem_ack = 1 (zero-wait access) or when there is no memory op.
  - WAIT → IDLE on dmem_ack = 1, or when the timeout fires.
- Bus outputs:
  - dmem_req = mem_op & (state is IDLE or WAIT) & ~timeout_fired.
  - dmem_we = (opcode == OPCODE_ST).
  - dmem_addr and dmem_wdata are driven from the registers only, so they stay stable while dmem_req is held.
- stall_mem = dmem_req & ~dmem_ack.
- Wait counter:
  - 8-bit counter.
  - Cleared in IDLE.
  - Increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES - 1 with no ack: timeout_fired, mem_timeout = 1, stall_mem = 0 and the FSM returns to IDLE. The instruction then leaves the stage with ir_wb_next = INST_BNE_EXCEPT.
- Result mux:
  - y_wb_next = dmem_rdata for LD/LDR when dmem_ack = 1.
  - Otherwise y_wb_next = y_mem.
- IR mux, in priority order:
  1. timeout → INST_BNE_EXCEPT.
  2. Otherwise ir_src_mem: IR_SRC_EXCEPT → INST_BNE_EXCEPT; IR_SRC_NOP → INST_NOP; IR_SRC_DATA → ir_mem.
  3. Any other encoding of ir_src_mem → 'x.
- pc_wb_next = pc_mem.
- While stalled, the writeback stage is fed INST_NOP (a bubble): ir_wb_next = INST_NOP whenever stall_mem = 1.

## Timing
- Reset values:
  - ir_mem = INST_NOP; pc_mem, y_mem, st_mem = 0.
  - state = IDLE; counter = 0.
  - dmem_req, stall_mem and mem_timeout are therefore 0, and ir_wb_next = INST_NOP (given ir_src_mem = IR_SRC_DATA).
- Latency:
  - Non-memory instructions: one cycle in the stage.
  - Zero-wait access: one cycle, with no stall.
  - N-wait access: 1 + N cycles, with stall_mem high for N cycles.
- The ack is only meaningful while dmem_req = 1. An ack in IDLE with no memory op, or in the cycle after a timeout, is ignored.
- A back-to-back memory op after a completed access issues its request in the very next cycle, with no idle cycle inserted.
- Reset mid-access: dmem_req drops asynchronously and the FSM goes to IDLE. A pending ack is ignored after reset.
- Simultaneous events:
  - dmem_ack arriving in the timeout cycle: the ack wins; data is taken and there is no timeout.
  - ir_src_mem = IR_SRC_NOP during a stall: still a NOP out.

## Structure
- defines.v package additions:
  - OPCODE_LD, OPCODE_ST, OPCODE_LDR.
  - State enum mem_state_t {MEM_IDLE, MEM_WAIT}.
- Existing package items reused: IR_SRC_* encodings, INST_NOP, INST_BNE_EXCEPT.
- Sub-module: dmem_if holds the FSM, the wait counter and the timeout logic. The parent holds the pipeline registers and the muxes.

## Test plan
- Reset asserted mid-WAIT (LD pending) → next cycle dmem_req = 0, stall_mem = 0, ir_wb_next = INST_NOP, state IDLE. A late dmem_ack = 1 causes no change.
- ADD with y_mem_next = 32'h0000_0010 → dmem_req stays 0, y_wb_next = 32'h10 one cycle later, no stall.
- LD with y = 32'h0000_0103, ack held high every cycle (zero-wait) → dmem_addr = 32'h100, dmem_we = 0. dmem_rdata = 32'hDEAD_BEEF appears on y_wb_next in the same cycle, stall_mem never asserts.
- ST with st = 32'h1234_5678 and ack after 3 cycles → stall_mem high for exactly 3 cycles. dmem_wdata and dmem_addr are stable throughout, and ir_wb_next = INST_NOP during the stall.
- LD with no ack, TIMEOUT_CYCLES = 4 → mem_timeout pulses on the 4th wait cycle, ir_wb_next = INST_BNE_EXCEPT, dmem_req drops, and the pipeline advances the next cycle.
- Ack arriving in the same cycle as the timeout → data is accepted, mem_timeout = 0, ir_wb_next = ir_mem.
